fifo_uart_tx: RTL
=================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit; legal range 2..65535.
REQ-002 SHALL have parameter DATA_W, default 8, meaning data bits per frame; fixed at 8 in this release.
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port fifo_empty  input  1  high when the upstream sync FIFO holds no data.
REQ-006 SHALL have port fifo_rdata  input  8  FIFO read data, valid in the cycle after fifo_read was high.
REQ-007 SHALL have port fifo_read  output  1  one-cycle read strobe to the FIFO.
REQ-008 SHALL have port tx  output  1  serial line, idle high.
REQ-009 SHALL have port busy  output  1  high whenever a frame is being fetched or sent.

Function
REQ-010 SHALL implement states IDLE, FETCH, WAIT, START, DATA, STOP.
REQ-011 IDLE: tx=1, busy=0; when fifo_empty=0 at a rising edge SHALL move to FETCH, else stay.
REQ-012 FETCH: lasts exactly 1 cycle; fifo_read=1 only in this state; SHALL move to WAIT.
REQ-013 WAIT: lasts 1 cycle; SHALL capture fifo_rdata into an 8-bit shift register at its end and move to START.
REQ-014 START: tx=0 for exactly CLKS_PER_BIT cycles, then DATA.
REQ-015 DATA: SHALL send 8 bits LSB first, each held CLKS_PER_BIT cycles; 3-bit bit counter wraps 7->0 on exit to STOP.
REQ-016 STOP: tx=1 for exactly CLKS_PER_BIT cycles, then IDLE.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 Frame timing: first start-bit cycle SHALL be 3 cycles after the edge where IDLE samples fifo_empty=0; back-to-back frames SHALL have exactly 3 tx-high cycles between stop bit end and next start bit (frame period 10*CLKS_PER_BIT+3).
REQ-019 fifo_read SHALL never be asserted while fifo_empty=1 is being sampled in IDLE; at most one read per frame.
REQ-020 fifo_empty changing during FETCH..STOP SHALL have no effect until the next IDLE.
REQ-021 tx SHALL be driven from a register (glitch-free); fifo_read SHALL be a decode of the state register.
REQ-022 Baud counter SHALL count 0..CLKS_PER_BIT-1 and reset to 0 on every state change; width ceil(log2(CLKS_PER_BIT)).

Reset
REQ-023 reset=0 SHALL immediately force state IDLE, tx=1, fifo_read=0, busy=0, counters and shift register to 0.
REQ-024 reset mid-frame SHALL abort the frame with no further fifo_read; the byte already read is discarded.
REQ-025 After reset release, first FETCH SHALL occur no earlier than the first rising edge with reset=1 and fifo_empty=0.

Structure
REQ-026 State encoding enum and default CLKS_PER_BIT SHALL live in shared package fifo_uart_pkg.
REQ-027 Baud counter SHALL be one sub-module, baud_counter (inputs clk, reset, clear; output tick on terminal count).
REQ-028 No other sub-modules; no combinational path from fifo_rdata to any output.

Verification (CLKS_PER_BIT=4, upstream FIFO model with 1-cycle read latency)
REQ-029 Reset held low 3 cycles with fifo_empty=0 -> tx=1, busy=0, fifo_read=0 throughout.
REQ-030 FIFO loaded with 0x55 -> one fifo_read pulse; tx = 0,1,0,1,0,1,0,1,0,1 bits (start, LSB first, stop), each 4 cycles, 40 cycles total, busy falls after stop.
REQ-031 FIFO loaded 0xAA, 0xF0, 0x0F -> 3 frames, period 43 cycles, exactly 3 fifo_read pulses, decoded bytes match in order.
REQ-032 fifo_empty=1 for 100 cycles -> no fifo_read, tx=1, busy=0.
REQ-033 reset pulled low mid-DATA of 0xF0 -> tx=1 within same cycle, next frame after release starts with the following FIFO byte.
REQ-034 fifo_empty toggled during a frame -> frame length unchanged, no extra fifo_read.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// Shared types and defaults for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    START,
    DATA,
    STOP
  } state_t;

endpackage

// File: rtl/baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, tick on terminal count, clear restarts at 0.
module baud_counter
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls bytes from a synchronous FIFO with 1-cycle read latency.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              fifo_read,
  output logic              tx,
  output logic              busy
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

  state_t            state, state_next;
  logic [2:0]        bit_cnt, bit_cnt_next;
  logic [DATA_W-1:0] shift_q, shift_next;
  logic              tx_q, tx_next;
  logic              tick;

  // Any state change restarts the bit period, so every phase gets a full CLKS_PER_BIT.
  baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .clear(state_next != state),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
      shift_q <= shift_next;
      tx_q    <= tx_next;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    shift_next   = shift_q;
    unique case (state)
      IDLE:  if (!fifo_empty) state_next = FETCH;
      FETCH: state_next = WAIT;
      WAIT: begin
        state_next = START;
        shift_next = fifo_rdata;
      end
      START: if (tick) state_next = DATA;
      DATA: begin
        if (tick) begin
          if (bit_cnt == LAST_BIT) begin
            state_next   = STOP;
            bit_cnt_next = '0;
          end else begin
            bit_cnt_next = bit_cnt + 3'd1;
            shift_next   = shift_q >> 1;
          end
        end
      end
      STOP:    if (tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // The line level is registered from the upcoming state, so tx changes exactly with the state.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  assign tx        = tx_q;
  assign fifo_read = (state == FETCH);
  assign busy      = (state != IDLE);

endmodule
